usbf_ep_data_port: RTL and testbench

- hclk-domain sequencer between the CSR endpoint-data register and the CDC synchronizer feeding the PHY-clock endpoint FIFOs.
- Turns one CSR data access into a single-cycle per-endpoint write or read request pulse.
- Holds TX data stable across the clock crossing, waits for the returned ready pulse, captures RX data and returns a response.
- Allows only one access in flight.

---
 rtl/usbf_ep_data_port_pkg.sv | 17 +
 rtl/usbf_ep_data_port.sv | 179 +++++++++++++++++
 tb/tb_usbf_ep_data_port.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usbf_ep_data_port_pkg.sv
// Shared types for the endpoint-data sequencer: FSM state encoding and default sizing.
// Pairs with usbf_ep_data_port; the timeout feature is enabled by USBF_EP_DATA_TIMEOUT_EN.
package usbf_ep_data_port_pkg;

    localparam int USBF_EP_NUM_DFLT = 4;
    localparam int USBF_EP_W_DFLT   = 2;
    localparam int USBF_DATA_W_DFLT = 8;
    localparam int USBF_TMO_W_DFLT  = 8;

    typedef enum logic [1:0] {
        USBF_EPD_IDLE    = 2'd0,
        USBF_EPD_WR_WAIT = 2'd1,
        USBF_EPD_RD_WAIT = 2'd2,
        USBF_EPD_RESP    = 2'd3
    } epd_state_e;

endpackage

// File: rtl/usbf_ep_data_port.sv
// hclk-domain sequencer turning one CSR data access into a per-endpoint FIFO request pulse.
// Optional `define USBF_EP_DATA_TIMEOUT_EN adds a WAIT timeout with per-direction stale flags.
module usbf_ep_data_port
    import usbf_ep_data_port_pkg::*;
#(
    parameter int EP_NUM = USBF_EP_NUM_DFLT,
    parameter int EP_W   = USBF_EP_W_DFLT,
    parameter int DATA_W = USBF_DATA_W_DFLT,
    parameter int TMO_W  = USBF_TMO_W_DFLT
) (
    input  logic                     hclk_i,
    input  logic                     rst_i,
    input  logic                     acc_valid_i,
    input  logic                     acc_write_i,
    input  logic [EP_W-1:0]          acc_ep_i,
    input  logic [DATA_W-1:0]        acc_wdata_i,
    output logic                     acc_ready_o,
    output logic                     rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    output logic [EP_NUM-1:0]        ep_data_wt_req_o,
    output logic [EP_NUM-1:0]        ep_data_rd_req_o,
    output logic [DATA_W*EP_NUM-1:0] ep_tx_data_o,
    input  logic [DATA_W*EP_NUM-1:0] ep_rx_data_i,
    input  logic                     mem_wt_ready_i,
    input  logic                     mem_rd_ready_i
);

    epd_state_e          state;
    logic [EP_W-1:0]     ep_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [EP_NUM-1:0]   ep_onehot;
    logic [DATA_W-1:0]   rx_sel;
    logic                ep_bad;
    logic                dir_blocked;

    // Widen by one bit so EP_NUM == 2**EP_W still compares correctly.
    assign ep_bad = {1'b0, acc_ep_i} >= (EP_W + 1)'(EP_NUM);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ep_onehot = '0;
        rx_sel    = '0;
        for (int i = 0; i < EP_NUM; i++) begin
            ep_onehot[i] = (acc_ep_i == EP_W'(i));
            if (ep_q == EP_W'(i)) begin
                rx_sel = ep_rx_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef USBF_EP_DATA_TIMEOUT_EN
    // Leaving on the increment that would reach all-ones gives 2**TMO_W-1 WAIT cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             stale_wt;
    logic             stale_rd;
    logic             tmo_hit;

    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign dir_blocked = acc_write_i ? stale_wt : stale_rd;

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            tmo_cnt  <= '0;
            stale_wt <= 1'b0;
            stale_rd <= 1'b0;
        end else begin
            if (state == USBF_EPD_WR_WAIT || state == USBF_EPD_RD_WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (mem_wt_ready_i) begin
                stale_wt <= 1'b0;
            end else if (state == USBF_EPD_WR_WAIT && tmo_hit) begin
                stale_wt <= 1'b1;
            end

            if (mem_rd_ready_i) begin
                stale_rd <= 1'b0;
            end else if (state == USBF_EPD_RD_WAIT && tmo_hit) begin
                stale_rd <= 1'b1;
            end
        end
    end
`else
    assign dir_blocked = 1'b0;
`endif

    assign acc_ready_o  = (state == USBF_EPD_IDLE) && !dir_blocked && !rst_i;
    assign busy_o       = (state != USBF_EPD_IDLE);
    assign ep_tx_data_o = {EP_NUM{tx_data_q}};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            state            <= USBF_EPD_IDLE;
            ep_q             <= '0;
            tx_data_q        <= '0;
            ep_data_wt_req_o <= '0;
            ep_data_rd_req_o <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_err_o        <= 1'b0;
            rsp_rdata_o      <= '0;
        end else begin
            ep_data_wt_req_o <= '0;
            ep_data_rd_req_o <= '0;
            rsp_valid_o      <= 1'b0;

            unique case (state)
                USBF_EPD_IDLE: begin
                    if (acc_valid_i && acc_ready_o) begin
                        ep_q <= acc_ep_i;
                        if (ep_bad) begin
                            state       <= USBF_EPD_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else if (acc_write_i) begin
                            tx_data_q        <= acc_wdata_i;
                            ep_data_wt_req_o <= ep_onehot;
                            state            <= USBF_EPD_WR_WAIT;
                        end else begin
                            ep_data_rd_req_o <= ep_onehot;
                            state            <= USBF_EPD_RD_WAIT;
                        end
                    end
                end

                USBF_EPD_WR_WAIT: begin
                    if (mem_wt_ready_i) begin
                        state       <= USBF_EPD_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                    end
`ifdef USBF_EP_DATA_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state       <= USBF_EPD_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end
`endif
                end

                USBF_EPD_RD_WAIT: begin
                    if (mem_rd_ready_i) begin
                        state       <= USBF_EPD_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= rx_sel;
                    end
`ifdef USBF_EP_DATA_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state       <= USBF_EPD_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end
`endif
                end

                USBF_EPD_RESP: begin
                    state       <= USBF_EPD_IDLE;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end

                default: state <= USBF_EPD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usbf_ep_data_port.sv
// Directed bench for usbf_ep_data_port with a response scoreboard; timeout steps run when
// USBF_EP_DATA_TIMEOUT_EN is defined, otherwise an indefinite-hold step runs instead.
module tb_usbf_ep_data_port;

    localparam int EP_NUM = 4;
    localparam int EP_W   = 3;
    localparam int DATA_W = 8;
    localparam int TMO_W  = 8;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    logic                     hclk = 1'b0;
    logic                     rst_i;
    logic                     acc_valid;
    logic                     acc_write;
    logic [EP_W-1:0]          acc_ep;
    logic [DATA_W-1:0]        acc_wdata;
    logic                     acc_ready;
    logic                     rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     busy;
    logic [EP_NUM-1:0]        wt_req;
    logic [EP_NUM-1:0]        rd_req;
    logic [DATA_W*EP_NUM-1:0] tx_data;
    logic [DATA_W*EP_NUM-1:0] rx_data;
    logic                     wt_ready;
    logic                     rd_ready;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rsp_seen  = 0;
    int   wt_pulses = 0;
    int   rd_pulses = 0;

    usbf_ep_data_port #(
        .EP_NUM(EP_NUM), .EP_W(EP_W), .DATA_W(DATA_W), .TMO_W(TMO_W)
    ) dut (
        .hclk_i           (hclk),
        .rst_i            (rst_i),
        .acc_valid_i      (acc_valid),
        .acc_write_i      (acc_write),
        .acc_ep_i         (acc_ep),
        .acc_wdata_i      (acc_wdata),
        .acc_ready_o      (acc_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_err_o        (rsp_err),
        .busy_o           (busy),
        .ep_data_wt_req_o (wt_req),
        .ep_data_rd_req_o (rd_req),
        .ep_tx_data_o     (tx_data),
        .ep_rx_data_i     (rx_data),
        .mem_wt_ready_i   (wt_ready),
        .mem_rd_ready_i   (rd_ready)
    );

    always #5 hclk = ~hclk;

    always @(negedge hclk) begin
        if (rsp_valid === 1'b1) rsp_seen++;
        if (|wt_req) wt_pulses++;
        if (|rd_req) rd_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    // Drive an access, confirm it is accepted, and leave in the cycle after acceptance.
    task automatic accept(input logic wr, input logic [EP_W-1:0] ep, input logic [DATA_W-1:0] d,
                          input string tag);
        acc_valid = 1'b1;
        acc_write = wr;
        acc_ep    = ep;
        acc_wdata = d;
        #1;
        check({tag, "_acc_ready"}, 64'(acc_ready), 64'd1);
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic push(input logic err, input logic [DATA_W-1:0] rdata);
        rsp_t r;
        r.err   = err;
        r.rdata = rdata;
        sb.push_back(r);
    endtask

    task automatic expect_rsp(input string tag);
        rsp_t r;
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=response expected=none_pending", tag);
        end else begin
            r = sb.pop_front();
            check({tag, "_rsp_err"}, 64'(rsp_err), 64'(r.err));
            check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(r.rdata));
        end
    endtask

    task automatic pulse_wt();
        wt_ready = 1'b1;
        tick();
        wt_ready = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        int snap_rsp;
        int snap_wt;
        int snap_rd;
        int cycles;

        rst_i     = 1'b1;
        acc_valid = 1'b0;
        acc_write = 1'b0;
        acc_ep    = '0;
        acc_wdata = '0;
        wt_ready  = 1'b0;
        rd_ready  = 1'b0;
        rx_data   = {8'h11, 8'h3C, 8'h77, 8'h99};

        tick(2);
        check("rst_acc_ready", 64'(acc_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_reqs", 64'({wt_req, rd_req}), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        rst_i = 1'b0;
        #1;
        check("idle_acc_ready", 64'(acc_ready), 64'd1);
        tick();

        // Write ep1 0xA5, ready six cycles after the request pulse.
        accept(1'b1, 3'd1, 8'hA5, "wr1");
        push(1'b0, 8'h00);
        check("wr1_wt_req", 64'(wt_req), 64'b0010);
        check("wr1_rd_req", 64'(rd_req), 64'd0);
        check("wr1_tx_data", 64'(tx_data), 64'hA5A5A5A5);
        check("wr1_busy", 64'(busy), 64'd1);
        check("wr1_wait_acc_ready", 64'(acc_ready), 64'd0);
        tick();
        check("wr1_wt_req_one_cycle", 64'(wt_req), 64'd0);
        tick(5);
        pulse_wt();
        expect_rsp("wr1");
        tick();
        check("wr1_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        check("wr1_idle", 64'(busy), 64'd0);

        // Read ep2, ready five cycles after the request pulse.
        accept(1'b0, 3'd2, 8'h00, "rd2");
        push(1'b0, 8'h3C);
        check("rd2_rd_req", 64'(rd_req), 64'b0100);
        check("rd2_wt_req", 64'(wt_req), 64'd0);
        check("rd2_tx_stable", 64'(tx_data), 64'hA5A5A5A5);
        tick(5);
        pulse_rd();
        expect_rsp("rd2");
        tick();

        // Read ep3 with ready in the first WAIT cycle.
        accept(1'b0, 3'd3, 8'h00, "rd3");
        push(1'b0, 8'h11);
        check("rd3_rd_req", 64'(rd_req), 64'b1000);
        pulse_rd();
        expect_rsp("rd3");
        tick();

        // Out-of-range endpoint: error next cycle, no request pulses.
        snap_wt = wt_pulses;
        snap_rd = rd_pulses;
        accept(1'b1, 3'd4, 8'hFF, "bad_ep");
        push(1'b1, 8'h00);
        expect_rsp("bad_ep");
        check("bad_ep_tx_stable", 64'(tx_data), 64'hA5A5A5A5);
        tick(2);
        check("bad_ep_no_wt_pulse", 64'(wt_pulses), 64'(snap_wt));
        check("bad_ep_no_rd_pulse", 64'(rd_pulses), 64'(snap_rd));
        check("bad_ep_idle", 64'(busy), 64'd0);

        // Stray read-ready in IDLE and wrong-direction ready in WR_WAIT are ignored.
        pulse_rd();
        tick();
        accept(1'b1, 3'd3, 8'h5A, "wr3");
        push(1'b0, 8'h00);
        check("wr3_wt_req", 64'(wt_req), 64'b1000);
        tick(3);
        snap_rsp = rsp_seen;
        pulse_rd();
        tick(2);
        check("wr3_still_busy", 64'(busy), 64'd1);
        check("wr3_no_early_rsp", 64'(rsp_seen), 64'(snap_rsp));
        pulse_wt();
        expect_rsp("wr3");
        check("wr3_tx_data", 64'(tx_data), 64'h5A5A5A5A);
        tick();

        // Reset while in RD_WAIT abandons the access.
        accept(1'b0, 3'd0, 8'h00, "rd0_rst");
        tick(2);
        rst_i = 1'b1;
        #1;
        check("rst_wait_acc_ready", 64'(acc_ready), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_wait_idle", 64'(busy), 64'd0);
        check("rst_wait_no_rsp", 64'(rsp_valid), 64'd0);
        check("rst_wait_tx_cleared", 64'(tx_data), 64'd0);
        snap_rsp = rsp_seen;
        pulse_rd();
        tick(2);
        check("rst_late_ready_ignored", 64'(rsp_seen), 64'(snap_rsp));
        check("rst_late_ready_idle", 64'(busy), 64'd0);
        check("rst_late_acc_ready", 64'(acc_ready), 64'd1);

`ifdef USBF_EP_DATA_TIMEOUT_EN
        // Withheld write ready: error after 255 WAIT cycles, then writes blocked until late ready.
        accept(1'b1, 3'd0, 8'h42, "tmo");
        push(1'b1, 8'h00);
        cycles = 1;
        while (rsp_valid !== 1'b1 && cycles < 400) begin
            tick();
            cycles++;
        end
        check("tmo_latency", 64'(cycles), 64'd256);
        expect_rsp("tmo");
        tick();
        snap_wt   = wt_pulses;
        acc_valid = 1'b1;
        acc_write = 1'b1;
        acc_ep    = 3'd1;
        acc_wdata = 8'h77;
        #1;
        check("stale_wr_blocked", 64'(acc_ready), 64'd0);
        acc_write = 1'b0;
        #1;
        check("stale_rd_open", 64'(acc_ready), 64'd1);
        acc_write = 1'b1;
        tick(3);
        check("stale_wr_held_idle", 64'(busy), 64'd0);
        check("stale_wr_no_pulse", 64'(wt_pulses), 64'(snap_wt));
        wt_ready = 1'b1;
        tick();
        wt_ready = 1'b0;
        check("stale_cleared_ready", 64'(acc_ready), 64'd1);
        push(1'b0, 8'h00);
        tick();
        acc_valid = 1'b0;
        check("post_stale_wt_req", 64'(wt_req), 64'b0010);
        check("post_stale_tx", 64'(tx_data), 64'h77777777);
        tick(2);
        pulse_wt();
        expect_rsp("post_stale");
        tick();
`else
        // Without the timeout a WAIT state holds until the matching ready.
        accept(1'b1, 3'd2, 8'h33, "hold");
        push(1'b0, 8'h00);
        snap_rsp = rsp_seen;
        tick(300);
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_no_rsp", 64'(rsp_seen), 64'(snap_rsp));
        pulse_wt();
        expect_rsp("hold");
        check("hold_tx", 64'(tx_data), 64'h33333333);
        tick();
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
